// File: rtl/mipi_csi_pkg.sv
// Shared types and header/trailer arithmetic for the CSI-2 packet scheduler.
// ECC is the CSI-2 Hamming code over the 24-bit header; CRC-16 is the reflected CCITT form.
package mipi_csi_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHsWait,
      StHdr,
      StPayload,
      StCrc,
      StEnd,
      StGap
   } state_e;

   localparam logic [5:0] LONG_DT_MIN = 6'h10;

   function automatic logic [7:0] ecc6(input logic [23:0] d);
      logic [5:0] p;
      p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16] ^
             d[20] ^ d[21] ^ d[22] ^ d[23];
      p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17] ^
             d[20] ^ d[21] ^ d[22] ^ d[23];
      p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18] ^
             d[20] ^ d[21] ^ d[22];
      p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19] ^
             d[20] ^ d[21] ^ d[23];
      p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^ d[19] ^
             d[20] ^ d[22] ^ d[23];
      p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^ d[19] ^
             d[21] ^ d[22] ^ d[23];
      return {2'b00, p};
   endfunction

   // x^16+x^12+x^5+1 processed LSB-first, hence the reflected constant 16'h8408.
   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[0] ^ b[i];
         r  = r >> 1;
         if (fb) r = r ^ 16'h8408;
      end
      return r;
   endfunction

endpackage

// File: rtl/mipi_csi_pkt_sched_if.sv
// Requester, control and PHY-side signals of the packet scheduler.
// The scheduler uses the master modport; the requesters/PHY side uses slave.
interface mipi_csi_pkt_sched_if;
   logic        enable;
   logic        req0, req1;
   logic [1:0]  vc0, vc1;
   logic [5:0]  dt0, dt1;
   logic [15:0] wc0, wc1;
   logic [7:0]  pl_data0, pl_data1;
   logic        pl_re0, pl_re1;
   logic        ack0, ack1;
   logic        hs_req;
   logic        re;
   logic [7:0]  data;
   logic        busy;

   modport master (
      input  enable, req0, req1, vc0, vc1, dt0, dt1, wc0, wc1, pl_data0, pl_data1, re,
      output pl_re0, pl_re1, ack0, ack1, hs_req, data, busy
   );

   modport slave (
      output enable, req0, req1, vc0, vc1, dt0, dt1, wc0, wc1, pl_data0, pl_data1, re,
      input  pl_re0, pl_re1, ack0, ack1, hs_req, data, busy
   );
endinterface

// File: rtl/mipi_csi_crc16.sv
// Byte-wise CRC-16 accumulator: init reloads 16'hFFFF, en folds in one byte.
module mipi_csi_crc16 (
   input  logic        clk_hs,
   input  logic        resetb,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  din,
   output logic [15:0] crc
);
   import mipi_csi_pkg::*;

   logic [15:0] crc_q;

   always_ff @(posedge clk_hs or negedge resetb) begin
      if (!resetb) begin
         crc_q <= 16'hFFFF;
      end else if (init) begin
         crc_q <= 16'hFFFF;
      end else if (en) begin
         crc_q <= crc16_byte(crc_q, din);
      end
   end

   assign crc = crc_q;
endmodule

// File: rtl/mipi_csi_pkt_sched.sv
// Two-port CSI-2 packet scheduler: round-robin grant, header/ECC, payload, CRC trailer,
// then an inter-packet gap before the next grant.
module mipi_csi_pkt_sched #(
   parameter int unsigned GAP_CYCLES  = 4,
   parameter logic [5:0]  LONG_DT_MIN = mipi_csi_pkg::LONG_DT_MIN
) (
   input logic                   clk_hs,
   input logic                   resetb,
   mipi_csi_pkt_sched_if.master  bus
);
   import mipi_csi_pkg::*;

   state_e      state_q, state_d;
   logic        port_q, port_d;
   logic        prio_q, prio_d;
   logic [1:0]  vc_q, vc_d;
   logic [5:0]  dt_q, dt_d;
   logic [15:0] wc_q, wc_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;

   logic [1:0]  req, pl_re, ack;
   logic        pick, last, hs_req, crc_en, crc_init, is_long;
   logic [7:0]  data, ecc, pl_sel;
   logic [15:0] crc;

   assign req     = {bus.req1, bus.req0};
   assign pick    = (req == 2'b11) ? prio_q : req[1];
   assign is_long = (dt_q >= LONG_DT_MIN);
   assign ecc     = ecc6({wc_q, vc_q, dt_q});
   assign pl_sel  = port_q ? bus.pl_data1 : bus.pl_data0;

   mipi_csi_crc16 u_crc (
      .clk_hs (clk_hs),
      .resetb (resetb),
      .init   (crc_init),
      .en     (crc_en),
      .din    (pl_sel),
      .crc    (crc)
   );

   always_comb begin
      state_d  = state_q;
      port_d   = port_q;
      prio_d   = prio_q;
      vc_d     = vc_q;
      dt_d     = dt_q;
      wc_d     = wc_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      data     = 8'h00;
      hs_req   = 1'b0;
      pl_re    = 2'b00;
      ack      = 2'b00;
      crc_en   = 1'b0;
      crc_init = 1'b0;
      last     = 1'b0;
      unique case (state_q)
         StIdle: begin
            crc_init = 1'b1;
            cnt_d    = '0;
            idx_d    = '0;
            if (bus.enable && (req != 2'b00)) begin
               port_d  = pick;
               prio_d  = ~pick;
               vc_d    = pick ? bus.vc1 : bus.vc0;
               dt_d    = pick ? bus.dt1 : bus.dt0;
               wc_d    = pick ? bus.wc1 : bus.wc0;
               state_d = StHsWait;
            end
         end
         StHsWait: begin
            hs_req = 1'b1;
            data   = {vc_q, dt_q};
            if (bus.re) begin
               idx_d   = 2'd1;
               state_d = StHdr;
            end
         end
         StHdr: begin
            hs_req = 1'b1;
            case (idx_q)
               2'd1:    data = wc_q[7:0];
               2'd2:    data = wc_q[15:8];
               2'd3:    data = ecc;
               default: data = {vc_q, dt_q};
            endcase
            if (bus.re) begin
               if (idx_q == 2'd3) begin
                  idx_d = '0;
                  if (!is_long) begin
                     last = 1'b1;
                  end else if (wc_q == 16'd0) begin
                     state_d = StCrc;
                  end else begin
                     cnt_d   = wc_q;
                     state_d = StPayload;
                  end
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         StPayload: begin
            hs_req        = 1'b1;
            data          = pl_sel;
            pl_re[port_q] = bus.re;
            crc_en        = bus.re;
            if (bus.re) begin
               if (cnt_q == 16'd1) begin
                  cnt_d   = '0;
                  state_d = StCrc;
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
         end
         StCrc: begin
            hs_req = 1'b1;
            data   = idx_q[0] ? crc[15:8] : crc[7:0];
            if (bus.re) begin
               if (idx_q[0]) last = 1'b1;
               else          idx_d = 2'd1;
            end
         end
         StEnd: begin
            if (!bus.re) begin
               cnt_d   = '0;
               state_d = StGap;
            end
         end
         StGap: begin
            cnt_d = cnt_q + 16'd1;
            if ((cnt_q + 16'd1) >= 16'(GAP_CYCLES)) begin
               cnt_d   = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (last) begin
         ack[port_q] = 1'b1;
         idx_d       = '0;
         state_d     = StEnd;
      end
   end

   always_ff @(posedge clk_hs or negedge resetb) begin
      if (!resetb) begin
         state_q <= StIdle;
         port_q  <= 1'b0;
         prio_q  <= 1'b0;
         vc_q    <= '0;
         dt_q    <= '0;
         wc_q    <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         prio_q  <= prio_d;
         vc_q    <= vc_d;
         dt_q    <= dt_d;
         wc_q    <= wc_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.data   = data;
   assign bus.hs_req = hs_req;
   assign bus.pl_re0 = pl_re[0];
   assign bus.pl_re1 = pl_re[1];
   assign bus.ack0   = ack[0];
   assign bus.ack1   = ack[1];
   assign bus.busy   = (state_q != StIdle);
endmodule

// File: tb/tb_mipi_csi_pkt_sched.sv
// Randomised bench for mipi_csi_pkt_sched: requester/PHY models drive the DUT and every
// packet's byte stream, grant order and payload reads are compared with a reference model.
module tb_mipi_csi_pkt_sched;
   localparam int unsigned GAP = 4;
   localparam logic [5:0]  LDT = 6'h10;
   // Syndrome column of each header bit; ECC is the XOR of the columns of the set bits.
   localparam logic [5:0] ECC_COL [24] = '{
      6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
      6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

   logic clk_hs = 1'b0;
   logic resetb;
   always #5 clk_hs = ~clk_hs;

   mipi_csi_pkt_sched_if bus();

   mipi_csi_pkt_sched #(.GAP_CYCLES(GAP), .LONG_DT_MIN(LDT)) dut (
      .clk_hs (clk_hs),
      .resetb (resetb),
      .bus    (bus)
   );

   int          n_cmp, n_err;
   logic [15:0] crc_tab [256];
   bit          pend [2];
   logic [1:0]  p_vc [2];
   logic [5:0]  p_dt [2];
   logic [15:0] p_wc [2];
   logic [7:0]  pay [2][16];
   int          ptr [2];
   int          prc [2];
   bit          enable_v, hs_prev, re_prev, active, prio;
   logic [1:0]  prev_req;
   int          re_mode, cur, cyc, fall_cyc, done_cnt, starts, last_grant;
   bit          gap_check, alt_check;
   logic [7:0]  expq [$];
   logic [7:0]  capt [$];
   logic [7:0]  last_capt [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] ecc_ref(input logic [23:0] h);
      logic [5:0] e;
      e = '0;
      for (int i = 0; i < 24; i++) if (h[i]) e = e ^ ECC_COL[i];
      return {2'b00, e};
   endfunction

   task automatic post(input int p, input logic [1:0] vc, input logic [5:0] dt,
                       input logic [15:0] wc);
      pend[p] = 1'b1;
      p_vc[p] = vc;
      p_dt[p] = dt;
      p_wc[p] = wc;
      ptr[p]  = 0;
      for (int i = 0; i < 16; i++) pay[p][i] = 8'($urandom_range(0, 255));
   endtask

   task automatic start_pkt();
      logic [23:0] h;
      logic [15:0] c;
      if (prev_req == 2'b11) cur = int'(prio);
      else                   cur = prev_req[1] ? 1 : 0;
      check("grant_req", 32'(prev_req[cur]), 32'd1);
      prio = (cur == 0);
      if (alt_check) check("alternate", cur, last_grant ^ 1);
      if (gap_check) check("gap", cyc - fall_cyc - 1, GAP + 1);
      last_grant = cur;
      starts++;
      h = {p_wc[cur], p_vc[cur], p_dt[cur]};
      expq.delete();
      expq.push_back(h[7:0]);
      expq.push_back(h[15:8]);
      expq.push_back(h[23:16]);
      expq.push_back(ecc_ref(h));
      if (p_dt[cur] >= LDT) begin
         c = 16'hFFFF;
         for (int i = 0; i < int'(p_wc[cur]); i++) begin
            expq.push_back(pay[cur][i]);
            c = (c >> 8) ^ crc_tab[c[7:0] ^ pay[cur][i]];
         end
         expq.push_back(c[7:0]);
         expq.push_back(c[15:8]);
      end
      capt.delete();
      prc[0] = 0;
      prc[1] = 0;
      active = 1'b1;
   endtask

   task automatic finish_pkt();
      check("ack_port", {30'd0, bus.ack1, bus.ack0}, (cur == 1) ? 32'd2 : 32'd1);
      check("stream_len", capt.size(), expq.size());
      for (int i = 0; i < expq.size(); i++)
         if (i < capt.size()) check("stream_byte", capt[i], expq[i]);
      check("pl_re_own", prc[cur], (p_dt[cur] >= LDT) ? int'(p_wc[cur]) : 0);
      check("pl_re_other", prc[1 - cur], 0);
      pend[cur] = 1'b0;
      active    = 1'b0;
      last_capt = capt;
      done_cnt++;
   endtask

   task automatic step();
      bit r;
      @(negedge clk_hs);
      bus.enable   = enable_v;
      bus.req0     = pend[0];
      bus.req1     = pend[1];
      bus.vc0      = p_vc[0];
      bus.vc1      = p_vc[1];
      bus.dt0      = p_dt[0];
      bus.dt1      = p_dt[1];
      bus.wc0      = p_wc[0];
      bus.wc1      = p_wc[1];
      bus.pl_data0 = pay[0][ptr[0] % 16];
      bus.pl_data1 = pay[1][ptr[1] % 16];
      case (re_mode)
         1:       r = 1'b1;
         2:       r = (cyc % 2) == 0;
         default: r = ($urandom_range(0, 3) != 0);
      endcase
      bus.re = hs_prev ? r : 1'b0;
      #1;
      if (bus.hs_req && !hs_prev) start_pkt();
      if (bus.hs_req && bus.re) capt.push_back(bus.data);
      if (bus.pl_re0) begin prc[0]++; ptr[0]++; end
      if (bus.pl_re1) begin prc[1]++; ptr[1]++; end
      if (bus.ack0 || bus.ack1) begin
         if (active) finish_pkt();
         else check("stray_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
      end
      if (re_prev && !bus.re) fall_cyc = cyc;
      hs_prev  = bus.hs_req;
      re_prev  = bus.re;
      prev_req = {bus.req1, bus.req0};
      cyc++;
   endtask

   task automatic run_until(input int target, input int budget);
      int n;
      n = 0;
      while (done_cnt < target && n < budget) begin step(); n++; end
      if (done_cnt < target) check("timeout", done_cnt, target);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((pend[0] || pend[1]) && n < budget) begin step(); n++; end
      check("drain", {30'd0, pend[1], pend[0]}, 32'd0);
   endtask

   task automatic wait_bytes(input int nb, input int budget);
      int n;
      n = 0;
      while (!(active && capt.size() >= nb) && n < budget) begin step(); n++; end
      check("reach_bytes", (active && capt.size() >= nb) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0]  lit [4];
      logic [15:0] t;
      int          n, target;
      lit = '{8'h00, 8'h01, 8'h00, 8'h1A};
      for (int i = 0; i < 256; i++) begin
         t = 16'(i);
         for (int b = 0; b < 8; b++) t = t[0] ? ((t >> 1) ^ 16'h8408) : (t >> 1);
         crc_tab[i] = t;
      end
      for (int p = 0; p < 2; p++) begin
         pend[p] = 0; p_vc[p] = 0; p_dt[p] = 0; p_wc[p] = 0; ptr[p] = 0; prc[p] = 0;
         for (int i = 0; i < 16; i++) pay[p][i] = 8'h00;
      end
      n_cmp = 0; n_err = 0; cyc = 0; fall_cyc = 0; done_cnt = 0; starts = 0; last_grant = 0;
      hs_prev = 0; re_prev = 0; active = 0; prio = 0; prev_req = 0; re_mode = 0;
      gap_check = 0; alt_check = 0; enable_v = 1;
      bus.enable = 1; bus.req0 = 0; bus.req1 = 0; bus.vc0 = 0; bus.vc1 = 0;
      bus.dt0 = 0; bus.dt1 = 0; bus.wc0 = 0; bus.wc1 = 0;
      bus.pl_data0 = 0; bus.pl_data1 = 0; bus.re = 0;
      resetb = 1'b0;
      repeat (2) @(negedge clk_hs);
      #1;
      check("rst_hs_req", 32'(bus.hs_req), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_data", 32'(bus.data), 32'd0);
      check("rst_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
      check("rst_pl_re", {30'd0, bus.pl_re1, bus.pl_re0}, 32'd0);
      resetb = 1'b1;

      // Short packet with the known header 00 01 00 1A.
      post(0, 2'd0, 6'h00, 16'h0001);
      run_until(1, 300);
      check("short_len", last_capt.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < last_capt.size()) check("short_byte", last_capt[i], lit[i]);

      // Long packet with no payload: empty CRC stays FFFF.
      post(1, 2'd1, 6'h2A, 16'h0000);
      run_until(2, 300);
      if (last_capt.size() == 6) check("crc_empty", {last_capt[5], last_capt[4]}, 16'hFFFF);
      else check("crc_empty_len", last_capt.size(), 6);

      // Three-byte payload with re alternating.
      re_mode = 2;
      post(0, 2'd2, 6'h24, 16'd3);
      run_until(3, 300);

      // Both ports requesting back to back: alternation and fixed gap.
      re_mode   = 1;
      alt_check = 1;
      target    = done_cnt + 8;
      n = 0;
      while (done_cnt < target && n < 3000) begin
         gap_check = (done_cnt > 3);
         for (int p = 0; p < 2; p++)
            if (!pend[p]) post(p, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                               16'($urandom_range(0, 4)));
         step();
         n++;
      end
      if (done_cnt < target) check("timeout_rr", done_cnt, target);
      alt_check = 0;
      gap_check = 0;
      drain(500);

      // Enable drops mid-payload: packet completes, no new grant while low.
      re_mode = 0;
      post(0, 2'd1, 6'h2B, 16'd8);
      wait_bytes(6, 300);
      enable_v = 0;
      post(1, 2'd3, 6'h12, 16'd2);
      n = 0;
      while (pend[0] && n < 300) begin step(); n++; end
      check("en_low_done", 32'(pend[0]), 32'd0);
      n = starts;
      repeat (40) step();
      check("no_grant_disabled", starts - n, 0);
      enable_v = 1;
      drain(300);

      // Reset in the middle of the header: immediate idle, no ack, pointer back to port 0.
      post(0, 2'd0, 6'h30, 16'd4);
      wait_bytes(2, 300);
      resetb = 1'b0;
      #1;
      check("rst_mid_hs_req", 32'(bus.hs_req), 32'd0);
      check("rst_mid_busy", 32'(bus.busy), 32'd0);
      check("rst_mid_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
      pend[0] = 0; pend[1] = 0; active = 0; prio = 0; hs_prev = 0; re_prev = 0;
      bus.req0 = 0; bus.req1 = 0;
      @(negedge clk_hs);
      resetb = 1'b1;
      repeat (20) step();
      post(0, 2'd1, 6'h01, 16'hBEEF);
      post(1, 2'd2, 6'h3F, 16'd1);
      target = done_cnt + 1;
      run_until(target, 300);
      check("rr_after_reset", last_grant, 0);
      drain(300);

      // Random traffic.
      re_mode = 0;
      target  = done_cnt + 16;
      n = 0;
      while (done_cnt < target && n < 8000) begin
         for (int p = 0; p < 2; p++)
            if (!pend[p] && $urandom_range(0, 7) == 0)
               post(p, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                    16'($urandom_range(0, 8)));
         step();
         n++;
      end
      if (done_cnt < target) check("timeout_rand", done_cnt, target);
      drain(500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
